apb_upio: RTL and testbench

APB_UPIO -- requirements
Module: apb_upio

---
 rtl/apb_upio.sv | 211 +++++++++++++++++++++
 tb/tb_apb_upio.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_upio.sv
`default_nettype none
// ============================================================================
//  Module   : apb_upio
//  Purpose  : APB slave for WIDTH user I/O pins. Provides output value and
//             direction registers, synchronised pin inputs, per-pin
//             rising/falling edge detection into a sticky STATUS register,
//             and a registered level interrupt.
//  Ports    : clk, rst_n          - clock, async active-low reset
//             PADDR_i..PENABLE_i  - APB request
//             PRDATA_o, PREADY_o,
//             PSLVERR_o           - APB response
//             upio_in_i           - asynchronous pin inputs
//             upio_out_o/dir_o    - pin output value / direction (1 = out)
//             int_o               - level interrupt
//  Revision : 1.0 - initial release
// ============================================================================
module apb_upio #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] PADDR_i,
    input  logic [31:0]       PWDATA_i,
    input  logic              PWRITE_i,
    input  logic              PSEL_i,
    input  logic              PENABLE_i,
    output logic [31:0]       PRDATA_o,
    output logic              PREADY_o,
    output logic              PSLVERR_o,
    input  logic [WIDTH-1:0]  upio_in_i,
    output logic [WIDTH-1:0]  upio_out_o,
    output logic [WIDTH-1:0]  upio_dir_o,
    output logic              int_o
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_setup  = 2'd1;
    localparam logic [1:0] c_st_access = 2'd2;

    localparam logic [2:0] c_reg_out     = 3'd0;
    localparam logic [2:0] c_reg_dir     = 3'd1;
    localparam logic [2:0] c_reg_in      = 3'd2;
    localparam logic [2:0] c_reg_rise_en = 3'd3;
    localparam logic [2:0] c_reg_fall_en = 3'd4;
    localparam logic [2:0] c_reg_status  = 3'd5;
    localparam logic [2:0] c_reg_irq_en  = 3'd6;
    localparam logic [2:0] c_reg_id      = 3'd7;

    localparam logic [31:0] c_id = {16'h5550, 8'd0, 8'(WIDTH)};

    logic [1:0]                        r_state;
    logic [1:0]                        w_state_nxt;
    logic                              r_rd_ready;
    logic [31:0]                       r_rdata;
    logic [WIDTH-1:0]                  r_out;
    logic [WIDTH-1:0]                  r_dir;
    logic [WIDTH-1:0]                  r_rise_en;
    logic [WIDTH-1:0]                  r_fall_en;
    logic [WIDTH-1:0]                  r_status;
    logic [WIDTH-1:0]                  r_irq_en;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_dly;
    logic                              r_int;

    logic [2:0]       w_idx;
    logic             w_hi_addr;
    logic             w_err;
    logic             w_in_access;
    logic             w_ready;
    logic             w_wr_en;
    logic             w_rd_cap;
    logic [31:0]      w_rd_mux;
    logic [WIDTH-1:0] w_sync_last;
    logic [WIDTH-1:0] w_evt;
    logic [WIDTH-1:0] w_w1c;
    logic             w_unused;

    // Byte-lane bits and write bits above WIDTH carry no information.
    assign w_unused = &{1'b0, PADDR_i[1:0], PWDATA_i};

    assign w_idx       = PADDR_i[4:2];
    assign w_hi_addr   = |PADDR_i[ADDR_W-1:5];
    assign w_err       = w_hi_addr | (PWRITE_i & ((w_idx == c_reg_in) | (w_idx == c_reg_id)));
    assign w_in_access = (r_state == c_st_access);
    // Reads spend their first ACCESS cycle fetching data (r_rd_ready low).
    assign w_ready     = w_in_access & (PWRITE_i | r_rd_ready);
    assign w_wr_en     = w_ready & PWRITE_i & PSEL_i & PENABLE_i & ~w_err;
    assign w_rd_cap    = w_in_access & ~PWRITE_i & ~r_rd_ready;

    // ------------------------------------------------------------------
    // APB state machine: next state and bus outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        PREADY_o    = 1'b0;
        PSLVERR_o   = 1'b0;
        PRDATA_o    = 32'h0;
        case (r_state)
            c_st_idle: begin
                if (PSEL_i && !PENABLE_i) w_state_nxt = c_st_setup;
            end
            c_st_setup: begin
                if (PENABLE_i)    w_state_nxt = c_st_access;
                else if (!PSEL_i) w_state_nxt = c_st_idle;
            end
            c_st_access: begin
                PREADY_o  = w_ready;
                PSLVERR_o = w_ready & w_err;
                if (r_rd_ready) PRDATA_o = r_rdata;
                if (w_ready) begin
                    w_state_nxt = (PSEL_i && !PENABLE_i) ? c_st_setup : c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_rd_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_ready <= w_rd_cap;
        end
    end

    // ------------------------------------------------------------------
    // Read data selection (captured during the read wait state)
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_mux = 32'h0;
        case (w_idx)
            c_reg_out:     w_rd_mux[WIDTH-1:0] = r_out;
            c_reg_dir:     w_rd_mux[WIDTH-1:0] = r_dir;
            c_reg_in:      w_rd_mux[WIDTH-1:0] = w_sync_last;
            c_reg_rise_en: w_rd_mux[WIDTH-1:0] = r_rise_en;
            c_reg_fall_en: w_rd_mux[WIDTH-1:0] = r_fall_en;
            c_reg_status:  w_rd_mux[WIDTH-1:0] = r_status;
            c_reg_irq_en:  w_rd_mux[WIDTH-1:0] = r_irq_en;
            c_reg_id:      w_rd_mux = c_id;
            default:       w_rd_mux = 32'h0;
        endcase
        if (w_err) w_rd_mux = 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 32'h0;
        end else if (w_rd_cap) begin
            r_rdata <= w_rd_mux;
        end
    end

    // ------------------------------------------------------------------
    // Pin synchroniser and edge detection
    // ------------------------------------------------------------------
    assign w_sync_last = r_sync[SYNC_STAGES-1];
    // Events are single-cycle pulses evaluated against the enables in
    // force at that moment, so enabling later never replays old history.
    assign w_evt = (w_sync_last & ~r_dly & r_rise_en) |
                   (~w_sync_last & r_dly & r_fall_en);
    assign w_w1c = (w_wr_en && (w_idx == c_reg_status)) ? PWDATA_i[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_dly  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], upio_in_i};
            r_dly  <= w_sync_last;
        end
    end

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out     <= '0;
            r_dir     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_irq_en  <= '0;
            r_status  <= '0;
            r_int     <= 1'b0;
        end else begin
            if (w_wr_en) begin
                case (w_idx)
                    c_reg_out:     r_out     <= PWDATA_i[WIDTH-1:0];
                    c_reg_dir:     r_dir     <= PWDATA_i[WIDTH-1:0];
                    c_reg_rise_en: r_rise_en <= PWDATA_i[WIDTH-1:0];
                    c_reg_fall_en: r_fall_en <= PWDATA_i[WIDTH-1:0];
                    c_reg_irq_en:  r_irq_en  <= PWDATA_i[WIDTH-1:0];
                    default: ;
                endcase
            end
            // A new event on the same bit as a clear keeps the bit set.
            r_status <= (r_status & ~w_w1c) | w_evt;
            r_int    <= |(r_status & r_irq_en);
        end
    end

    assign upio_out_o = r_out;
    assign upio_dir_o = r_dir;
    assign int_o      = r_int;

endmodule
`default_nettype wire

// File: tb/tb_apb_upio.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_upio
//  Purpose  : Self-checking bench for apb_upio. Bus responses are predicted
//             from a register-map model and queued; a monitor compares them
//             whenever the slave signals PREADY.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_upio;

    localparam int WIDTH  = 8;
    localparam int SYNC   = 2;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] paddr = '0;
    logic [31:0]       pwdata = '0;
    logic              pwrite = 1'b0;
    logic              psel = 1'b0;
    logic              penable = 1'b0;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;
    logic [WIDTH-1:0]  pins = '0;
    logic [WIDTH-1:0]  upio_out;
    logic [WIDTH-1:0]  upio_dir;
    logic              irq;

    always #5 clk = ~clk;

    apb_upio #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PADDR_i    (paddr),
        .PWDATA_i   (pwdata),
        .PWRITE_i   (pwrite),
        .PSEL_i     (psel),
        .PENABLE_i  (penable),
        .PRDATA_o   (prdata),
        .PREADY_o   (pready),
        .PSLVERR_o  (pslverr),
        .upio_in_i  (pins),
        .upio_out_o (upio_out),
        .upio_dir_o (upio_dir),
        .int_o      (irq)
    );

    typedef struct {
        logic [31:0]       data;
        logic              err;
        bit                chk_data;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    logic [WIDTH-1:0] m_out = '0, m_dir = '0, m_rise = '0, m_fall = '0;
    logic [WIDTH-1:0] m_status = '0, m_irq = '0, m_pins = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_is_err(input logic [ADDR_W-1:0] a, input bit wr);
        int w;
        w = int'(a) / 4;
        return (w >= 8) || (wr && (w == 2 || w == 7));
    endfunction

    function automatic logic [31:0] m_read(input logic [ADDR_W-1:0] a);
        logic [31:0] regs [8];
        int w;
        w = int'(a) / 4;
        if (w >= 8) return 32'h0;
        regs[0] = 32'(m_out);
        regs[1] = 32'(m_dir);
        regs[2] = 32'(m_pins);
        regs[3] = 32'(m_rise);
        regs[4] = 32'(m_fall);
        regs[5] = 32'(m_status);
        regs[6] = 32'(m_irq);
        regs[7] = 32'h5550_0000 + WIDTH;
        return regs[w];
    endfunction

    function automatic void m_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        if (m_is_err(a, 1'b1)) return;
        case (int'(a) / 4)
            0: m_out    = d[WIDTH-1:0];
            1: m_dir    = d[WIDTH-1:0];
            3: m_rise   = d[WIDTH-1:0];
            4: m_fall   = d[WIDTH-1:0];
            5: m_status = m_status & ~d[WIDTH-1:0];
            6: m_irq    = d[WIDTH-1:0];
            default: ;
        endcase
    endfunction

    // Pin transition as seen by the model: sticky status gains enabled edges.
    function automatic void m_pin_change(input logic [WIDTH-1:0] v);
        m_status = m_status | (v & ~m_pins & m_rise) | (~v & m_pins & m_fall);
        m_pins   = v;
    endfunction

    // All stimulus tasks are entered and left just after a rising edge.
    task automatic apb(input logic [ADDR_W-1:0] a, input logic [31:0] d, input bit wr);
        exp_t e;
        bit   ok;
        int   lat;
        e.err      = m_is_err(a, wr);
        e.data     = wr ? 32'h0 : m_read(a);
        e.chk_data = !wr;
        e.addr     = a;
        sbq.push_back(e);
        paddr = a; pwdata = d; pwrite = wr; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        ok = 1'b0;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (pready) begin
                ok = 1'b1;
                lat = i;
                break;
            end
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL apb_timeout: addr %h got no PREADY within 8 cycles", a);
        end else begin
            chk(wr ? "wr_latency" : "rd_latency", lat, wr ? 1 : 2);
        end
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        if (wr) m_write(a, d);
    endtask

    task automatic set_pins(input logic [WIDTH-1:0] v);
        pins = v;
        m_pin_change(v);
        repeat (SYNC + 3) @(posedge clk);
        #1;
    endtask

    task automatic check_outs();
        @(posedge clk);
        @(negedge clk);
        chk("upio_out", upio_out, m_out);
        chk("upio_dir", upio_dir, m_dir);
        chk("int_o", irq, |(m_status & m_irq));
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && pready) begin
            if (sbq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_pready: actual 1 required 0 (t=%0t)", $time);
            end else begin
                e = sbq.pop_front();
                chk("pslverr", pslverr, e.err);
                if (e.chk_data) chk("prdata", prdata, e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
        int                k;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pready", pready, 0);
        chk("rst_prdata", prdata, 0);
        chk("rst_pslverr", pslverr, 0);
        chk("rst_out", upio_out, 0);
        chk("rst_dir", upio_dir, 0);
        chk("rst_int", irq, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ID read
        apb(12'h01C, 32'h0, 1'b0);

        // Direction and output values
        apb(12'h004, 32'hFFFF_FFF0, 1'b1);
        apb(12'h000, 32'h0000_00A5, 1'b1);
        check_outs();
        apb(12'h004, 32'h0, 1'b0);
        apb(12'h000, 32'h0, 1'b0);

        // Rising edge on pin 0 with exact interrupt latency
        apb(12'h00C, 32'h01, 1'b1);
        apb(12'h018, 32'h01, 1'b1);
        pins = m_pins | 8'h01;
        m_pin_change(pins);
        repeat (SYNC + 1) @(posedge clk);
        @(negedge clk);
        chk("int_early", irq, 0);
        @(posedge clk);
        @(negedge clk);
        chk("int_on_time", irq, 1);
        @(posedge clk); #1;
        apb(12'h014, 32'h0, 1'b0);
        apb(12'h014, 32'h01, 1'b1);
        check_outs();

        // Falling edge on pin 3 coincident with its W1C
        apb(12'h010, 32'h08, 1'b1);
        apb(12'h018, 32'h09, 1'b1);
        set_pins(m_pins | 8'h08);
        set_pins(m_pins & ~8'h08);
        set_pins(m_pins | 8'h08);
        check_outs();
        pins = m_pins & ~8'h08;
        repeat (SYNC - 2) begin @(posedge clk); #1; end
        apb(12'h014, 32'h08, 1'b1);
        m_pin_change(pins);
        check_outs();
        apb(12'h014, 32'h0, 1'b0);

        // Error accesses
        apb(12'h008, 32'hFF, 1'b1);
        apb(12'h040, 32'h0, 1'b0);
        apb(12'h008, 32'h0, 1'b0);

        // Randomised traffic
        for (int it = 0; it < 150; it++) begin
            k = $urandom_range(0, 9);
            d = $urandom();
            if (k <= 3) begin
                a = ADDR_W'($urandom_range(0, 31));
                apb(a, d, 1'b1);
            end else if (k <= 6) begin
                a = ADDR_W'($urandom_range(0, 31));
                apb(a, d, 1'b0);
            end else if (k == 7) begin
                a = ADDR_W'($urandom_range(32, 4095));
                apb(a, d, ($urandom_range(0, 1) == 1));
            end else begin
                set_pins(WIDTH'($urandom()));
            end
            if (it % 10 == 9) check_outs();
        end

        // Reset during read wait state
        apb(12'h000, 32'h5A, 1'b1);
        apb(12'h004, 32'h3C, 1'b1);
        paddr = 12'h000; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #2;
        chk("wait_state_pready", pready, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_out", upio_out, 0);
        chk("arst_dir", upio_dir, 0);
        chk("arst_int", irq, 0);
        chk("arst_pready", pready, 0);
        chk("arst_pslverr", pslverr, 0);
        chk("arst_prdata", prdata, 0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_status = '0; m_irq = '0;
        repeat (SYNC + 3) @(posedge clk);
        #1;
        apb(12'h000, 32'h0, 1'b0);
        apb(12'h004, 32'h0, 1'b0);
        check_outs();

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
